// File: rtl/vgpr_clear_arbiter_pkg.sv
// Shared constants for the VGPR clear arbiter: address width, default sizing
// and the width macro used for FIFO pointers, counts and grant indices.
`ifndef VGPR_ADDR_LENGTH
`define VGPR_ADDR_LENGTH 10
`endif

`ifndef VGPR_CLR_WIDTH
`define VGPR_CLR_WIDTH(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package vgpr_clear_arbiter_pkg;
    localparam int VGPR_ADDR_W = `VGPR_ADDR_LENGTH;
    localparam int NUM_REQ_DEF = 4;
    localparam int DEPTH_DEF   = 2;
endpackage

// File: rtl/vgpr_clear_fifo.sv
// Per-requester retire FIFO: DEPTH x ADDR_W storage, wrapping pointers and an
// occupancy count; exposes head, empty and full.
module vgpr_clear_fifo
    import vgpr_clear_arbiter_pkg::*;
#(
    parameter int ADDR_W = VGPR_ADDR_W,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    output logic [ADDR_W-1:0] head,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = `VGPR_CLR_WIDTH(DEPTH);
    localparam int CNT_W = `VGPR_CLR_WIDTH(DEPTH + 1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full));
            assert (!(pop && empty));
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_addr;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
endmodule

// File: rtl/vgpr_clear_arbiter.sv
// Round-robin arbiter sharing the single VALU VGPR clear port among NUM_REQ
// retire FIFOs. Optional macro VGPR_CLEAR_ARB_BYPASS_EN lets an empty FIFO's
// incoming request compete in the same cycle.
module vgpr_clear_arbiter
    import vgpr_clear_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = VGPR_ADDR_W,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      clr_valid,
    output logic [ADDR_W-1:0]         clr_addr,
    output logic                      idle
);
    localparam int IDX_W = `VGPR_CLR_WIDTH(NUM_REQ);

    logic [ADDR_W-1:0]  head [NUM_REQ];
    logic [NUM_REQ-1:0] empty;
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] bypass_take;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   gnt_idx_p0;
    logic               gnt_vld_p0;
    logic [ADDR_W-1:0]  gnt_addr_p0;
    int                 rr_idx;

    assign req_ready = ~full;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        vgpr_clear_fifo #(
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_addr (req_addr[i*ADDR_W +: ADDR_W]),
            .pop       (pop[i]),
            .head      (head[i]),
            .empty     (empty[i]),
            .full      (full[i])
        );
    end

`ifdef VGPR_CLEAR_ARB_BYPASS_EN
    assign eligible = ~empty | (req_valid & empty);
`else
    assign eligible = ~empty;
`endif

    // Grant stage p0: first eligible requester after last_grant, wrapping.
    always_comb begin
        gnt_vld_p0 = 1'b0;
        gnt_idx_p0 = '0;
        rr_idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(last_grant) + k) % NUM_REQ;
            if (!gnt_vld_p0 && eligible[rr_idx]) begin
                gnt_vld_p0 = 1'b1;
                gnt_idx_p0 = IDX_W'(rr_idx);
            end
        end
    end

    always_comb begin
        gnt_addr_p0 = head[gnt_idx_p0];
`ifdef VGPR_CLEAR_ARB_BYPASS_EN
        if (empty[gnt_idx_p0])
            gnt_addr_p0 = req_addr[int'(gnt_idx_p0)*ADDR_W +: ADDR_W];
`endif
    end

    // A winner with an empty FIFO can only be a bypassed request; it skips the FIFO.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i]         = gnt_vld_p0 && (gnt_idx_p0 == IDX_W'(i)) && !empty[i];
            bypass_take[i] = gnt_vld_p0 && (gnt_idx_p0 == IDX_W'(i)) && empty[i];
            push[i]        = req_valid[i] && !full[i] && !bypass_take[i];
        end
    end

    // Output register p1: drives the busy-table clear port.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_valid  <= 1'b0;
            clr_addr   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            clr_valid <= gnt_vld_p0;
            if (gnt_vld_p0) begin
                clr_addr   <= gnt_addr_p0;
                last_grant <= gnt_idx_p0;
            end
        end
    end

    assign idle = (&empty) && !clr_valid;
endmodule

// File: tb/tb_vgpr_clear_arbiter.sv
// Self-checking bench for vgpr_clear_arbiter: per-requester address queues and a
// round-robin pointer predict every clear, ready and idle value cycle by cycle.
module tb_vgpr_clear_arbiter;
    import vgpr_clear_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 2;
`ifdef VGPR_CLEAR_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      clr_valid;
    logic [ADDR_W-1:0]         clr_addr;
    logic                      idle;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0]  q [NUM_REQ][$];
    int                 last_gnt;
    logic               exp_valid;
    logic [ADDR_W-1:0]  exp_addr;
    logic [NUM_REQ-1:0] acc;

    vgpr_clear_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .clr_valid (clr_valid),
        .clr_addr  (clr_addr),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NUM_REQ; i++) q[i].delete();
        last_gnt  = NUM_REQ - 1;
        exp_valid = 1'b0;
        exp_addr  = '0;
        acc       = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a);
        req_valid[i] = v;
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    // One clock: predict from pre-edge inputs, clock, then compare outputs.
    task automatic tick();
        logic [NUM_REQ-1:0] rdy_m;
        int w;
        int idx;
        bit byp;
        for (int i = 0; i < NUM_REQ; i++) rdy_m[i] = (q[i].size() < DEPTH);
        total++;
        if (req_ready !== rdy_m) begin
            bad++;
            $display("FAIL req_ready got=%b exp=%b t=%0t", req_ready, rdy_m, $time);
        end
        if (rst) begin
            model_reset();
        end else begin
            w = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (last_gnt + k) % NUM_REQ;
                if (w < 0 && (q[idx].size() > 0 || (BYP && req_valid[idx])))
                    w = idx;
            end
            byp = 1'b0;
            exp_valid = (w >= 0);
            if (w >= 0) begin
                if (q[w].size() == 0) begin
                    byp = 1'b1;
                    exp_addr = req_addr[w*ADDR_W +: ADDR_W];
                end else begin
                    exp_addr = q[w].pop_front();
                end
                last_gnt = w;
            end
            acc = req_valid & rdy_m;
            for (int i = 0; i < NUM_REQ; i++)
                if (acc[i] && !(byp && w == i))
                    q[i].push_back(req_addr[i*ADDR_W +: ADDR_W]);
        end
        @(posedge clk);
        #1;
        total++;
        if (clr_valid !== exp_valid) begin
            bad++;
            $display("FAIL clr_valid got=%b exp=%b t=%0t", clr_valid, exp_valid, $time);
        end
        total++;
        if (clr_addr !== exp_addr) begin
            bad++;
            $display("FAIL clr_addr got=%h exp=%h t=%0t", clr_addr, exp_addr, $time);
        end
        begin
            logic exp_idle;
            exp_idle = !exp_valid;
            for (int i = 0; i < NUM_REQ; i++) if (q[i].size() != 0) exp_idle = 1'b0;
            total++;
            if (idle !== exp_idle) begin
                bad++;
                $display("FAIL idle got=%b exp=%b t=%0t", idle, exp_idle, $time);
            end
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++;
        if (clr_valid !== 1'b0 || clr_addr !== '0) begin
            bad++;
            $display("FAIL reset_clr got=%b/%h exp=0/000", clr_valid, clr_addr);
        end
        total++;
        if (idle !== 1'b1 || req_ready !== '1) begin
            bad++;
            $display("FAIL reset_state idle=%b ready=%b exp=1/1111", idle, req_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        set_req(0, 1'b1, 10'h05A);
        tick();
        set_req(0, 1'b0, '0);
        lat = 1;
        while (!clr_valid && lat < 10) begin
            tick();
            lat++;
        end
        total++;
        if (lat != (BYP ? 1 : 2) || clr_addr !== 10'h05A) begin
            bad++;
            $display("FAIL single_latency got=%0d/%h exp=%0d/05a", lat, clr_addr, BYP ? 1 : 2);
        end
        tick();
        total++;
        if (idle !== 1'b1) begin
            bad++;
            $display("FAIL single_idle got=%b exp=1", idle);
        end
    endtask

    task automatic test_all_four();
        logic [ADDR_W-1:0] got [$];
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, ADDR_W'((i + 1) * 16));
        tick();
        req_valid = '0;
        if (clr_valid) got.push_back(clr_addr);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (clr_valid) got.push_back(clr_addr);
        end
        total++;
        if (got.size() != 4) begin
            bad++;
            $display("FAIL all_four_count got=%0d exp=4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got[k] !== ADDR_W'((k + 1) * 16)) begin
                    bad++;
                    $display("FAIL all_four_order[%0d] got=%h exp=%h", k, got[k], (k + 1) * 16);
                end
            end
        end
    endtask

    task automatic test_no_starve();
        int n2;
        int c;
        bit seen;
        do_reset();
        set_req(2, 1'b1, 10'h200 | ADDR_W'($urandom_range(0, 255)));
        for (int k = 0; k < 6; k++) begin
            tick();
            if (acc[2]) set_req(2, 1'b1, 10'h200 | ADDR_W'($urandom_range(0, 255)));
        end
        set_req(1, 1'b1, 10'h111);
        c = 0;
        while (c < 10) begin
            tick();
            c++;
            if (acc[2]) set_req(2, 1'b1, 10'h200 | ADDR_W'($urandom_range(0, 255)));
            if (acc[1]) begin
                set_req(1, 1'b0, '0);
                break;
            end
        end
        n2 = 0;
        seen = 1'b0;
        if (clr_valid && clr_addr == 10'h111) seen = 1'b1;
        else if (clr_valid && clr_addr[9:8] == 2'd2) n2++;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick();
            if (acc[2]) set_req(2, 1'b1, 10'h200 | ADDR_W'($urandom_range(0, 255)));
            if (clr_valid && clr_addr == 10'h111) seen = 1'b1;
            else if (clr_valid && clr_addr[9:8] == 2'd2) n2++;
        end
        total++;
        if (!seen || n2 > 1) begin
            bad++;
            $display("FAIL no_starve seen=%b req2_grants=%0d exp=1/<=1", seen, n2);
        end
        req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_full_hold();
        int pushes3;
        logic [ADDR_W-1:0] got3 [$];
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, {2'(i), 8'($urandom_range(0, 255))});
        set_req(3, 1'b1, 10'h300);
        pushes3 = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (clr_valid && clr_addr[9:8] == 2'd3) got3.push_back(clr_addr);
            for (int i = 0; i < 3; i++)
                if (acc[i]) set_req(i, c < 30, {2'(i), 8'($urandom_range(0, 255))});
            if (acc[3]) begin
                pushes3++;
                if (pushes3 < 3) set_req(3, 1'b1, 10'h300 + ADDR_W'(pushes3));
                else set_req(3, 1'b0, '0);
            end
            if (c == 1) begin
                total++;
                if (req_ready[3] !== 1'b0 || pushes3 != 2) begin
                    bad++;
                    $display("FAIL full_ready got=%b pushes=%0d exp=0/2", req_ready[3], pushes3);
                end
            end
        end
        total++;
        if (got3.size() != 3) begin
            bad++;
            $display("FAIL full_count got=%0d exp=3", got3.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (got3[k] !== 10'h300 + ADDR_W'(k)) begin
                    bad++;
                    $display("FAIL full_order[%0d] got=%h exp=%h", k, got3[k], 10'h300 + k);
                end
            end
        end
        req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, ADDR_W'($urandom_range(0, 1023)));
            tick();
        end
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        total++;
        if (clr_valid !== 1'b0 || req_ready !== '1 || idle !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid got=%b/%b/%b exp=0/1111/1", clr_valid, req_ready, idle);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (clr_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_stale got=%b exp=0", clr_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] got [$];
        do_reset();
        set_req(0, 1'b1, 10'h0A1);
        tick();
        if (clr_valid) got.push_back(clr_addr);
        set_req(0, 1'b1, 10'h0A2);
        tick();
        if (clr_valid) got.push_back(clr_addr);
        set_req(0, 1'b0, '0);
        for (int c = 0; c < 4; c++) begin
            tick();
            if (clr_valid) got.push_back(clr_addr);
        end
        total++;
        if (got.size() != 2 || got[0] !== 10'h0A1 || got[1] !== 10'h0A2) begin
            bad++;
            $display("FAIL b2b_order n=%0d got=%h,%h exp=0a1,0a2", got.size(),
                     got.size() > 0 ? got[0] : '0, got.size() > 1 ? got[1] : '0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || acc[i])
                    set_req(i, $urandom_range(0, 99) < 60, ADDR_W'($urandom_range(0, 1023)));
            end
        end
        req_valid = '0;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_no_starve();
        test_full_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
